// File: rtl/dm_arbiter_if.sv
// Data-memory bus bundle shared by the CPU datapath, the debug/loader port and the RAM.
// The arbiter takes the slave view; the environment (CPU, debug, RAM) takes the master view.
interface dm_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Shares the single-port sync-read data RAM between CPU datapath and debug port; grant is
// same-cycle, CPU read data next cycle, debug read data registered two cycles after grant.
// CPU has priority and is stalled only by a debug slot; DM_ARB_STARVE_GUARD_EN adds a forced
// debug slot after MAX_WAIT waiting cycles, otherwise debug only uses cycles the CPU leaves idle.
module dm_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    dm_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {SRC_NONE, SRC_CPU, SRC_DBG} rd_src_t;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dm_arbiter: MAX_WAIT must be in 1..15");
    end

    logic              cpu_act;
    logic              dbg_gnt;
    logic              cpu_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    rd_src_t           rd_src;
    rd_src_t           rd_src_nxt;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;

    assign cpu_act = bus.cpu_rd | bus.cpu_wr;

    // Grants are qualified with rst_n so nothing reaches the RAM while reset is held.
`ifdef DM_ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt;
    logic       force_slot;

    assign force_slot = (wait_cnt == 4'(MAX_WAIT));
    assign dbg_gnt    = rst_n & bus.dbg_req & (~cpu_act | force_slot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!bus.dbg_req || dbg_gnt) begin
            wait_cnt <= 4'd0;
        end else if (!force_slot) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign dbg_gnt = rst_n & bus.dbg_req & ~cpu_act;
`endif

    assign cpu_gnt = rst_n & cpu_act & ~dbg_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (dbg_gnt) begin
            mem_addr  = bus.dbg_addr;
            mem_wdata = bus.dbg_wdata;
            mem_we    = bus.dbg_we;
            mem_re    = ~bus.dbg_we;
        end else if (cpu_gnt) begin
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wdata;
            mem_we    = bus.cpu_wr;
            mem_re    = ~bus.cpu_wr;
        end
    end

    // Read-return owner: state register, next-state and output processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_src <= SRC_NONE;
        else        rd_src <= rd_src_nxt;
    end

    always_comb begin
        rd_src_nxt = SRC_NONE;
        if (dbg_gnt && !bus.dbg_we)     rd_src_nxt = SRC_DBG;
        else if (cpu_gnt && !bus.cpu_wr) rd_src_nxt = SRC_CPU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold   <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= (rd_src == SRC_DBG);
            if (rd_src == SRC_CPU) cpu_hold  <= bus.mem_rdata;
            if (rd_src == SRC_DBG) dbg_rdata <= bus.mem_rdata;
        end
    end

    assign bus.cpu_rdata  = (rd_src == SRC_CPU) ? bus.mem_rdata : cpu_hold;
    assign bus.cpu_stall  = cpu_act & dbg_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.dbg_rdata  = dbg_rdata;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_we     = mem_we;
    assign bus.mem_re     = mem_re;
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural sync-read RAM; expectations depend on
// whether DM_ARB_STARVE_GUARD_EN is defined.
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    dm_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    dm_arbiter #(.ADDR_W(11), .DATA_W(16), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:2047];

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    function automatic logic [15:0] init_val(input logic [10:0] a);
        return 16'hA500 ^ {5'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = init_val(11'(i));
        bus.mem_rdata = 16'h0;

        // Reset held with both requesters active.
        rst_n         = 1'b0;
        bus.cpu_rd    = 1'b1;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 11'h005;
        bus.cpu_wdata = 16'h5555;
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 11'h003;
        bus.dbg_wdata = 16'h7777;
        repeat (3) tick();
        sample();
        chk("rst_mem_we",    32'(bus.mem_we),     32'd0);
        chk("rst_mem_re",    32'(bus.mem_re),     32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),   32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata),  32'd0);
        chk("rst_dbg_gnt",   32'(bus.dbg_gnt),    32'd0);
        chk("rst_stall",     32'(bus.cpu_stall),  32'd0);
        chk("rst_rvalid",    32'(bus.dbg_rvalid), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata),  32'd0);
        chk("rst_dbg_rdata", 32'(bus.dbg_rdata),  32'd0);

        // First CPU read after release.
        tick();
        rst_n       = 1'b1;
        bus.dbg_req = 1'b0;
        sample();
        chk("cpu_rd_mem_re",   32'(bus.mem_re),   32'd1);
        chk("cpu_rd_mem_addr", 32'(bus.mem_addr), 32'h005);
        tick();
        bus.cpu_rd = 1'b0;
        sample();
        chk("cpu_rd_data", 32'(bus.cpu_rdata), 32'(init_val(11'h005)));
        chk("idle_mem_re", 32'(bus.mem_re),    32'd0);

        // Debug write then read-back with the CPU idle.
        tick();
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 11'h00A;
        bus.dbg_wdata = 16'hBEEF;
        sample();
        chk("dbg_wr_gnt",   32'(bus.dbg_gnt),   32'd1);
        chk("dbg_wr_we",    32'(bus.mem_we),    32'd1);
        chk("dbg_wr_addr",  32'(bus.mem_addr),  32'h00A);
        chk("dbg_wr_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        tick();
        bus.dbg_we = 1'b0;
        sample();
        chk("dbg_rd_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("dbg_rd_re",  32'(bus.mem_re),  32'd1);
        tick();
        bus.dbg_req = 1'b0;
        sample();
        chk("dbg_rd_n1_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        tick();
        sample();
        chk("dbg_rd_n2_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("dbg_rd_n2_data",   32'(bus.dbg_rdata),  32'hBEEF);
        tick();
        sample();
        chk("dbg_rd_n3_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("dbg_rd_n3_hold",   32'(bus.dbg_rdata),  32'hBEEF);

        // Back-to-back debug reads: one grant and one rvalid per cycle, two cycles later.
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.dbg_req  = (k < 4);
            bus.dbg_we   = 1'b0;
            bus.dbg_addr = 11'h020 + 11'(k);
            sample();
            chk($sformatf("b2b_gnt_%0d", k), 32'(bus.dbg_gnt), 32'(k < 4));
            chk($sformatf("b2b_rvalid_%0d", k), 32'(bus.dbg_rvalid), 32'(k >= 2));
            if (k >= 2)
                chk($sformatf("b2b_data_%0d", k), 32'(bus.dbg_rdata),
                    32'(init_val(11'h020 + 11'(k - 2))));
        end

        // Continuous CPU reads with debug waiting.
        tick();
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 11'h040;
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 11'h030;
        for (int k = 1; k <= 12; k++) begin
            logic exp_gnt;
            logic exp_rv;
`ifdef DM_ARB_STARVE_GUARD_EN
            exp_gnt = (k == 9);
            exp_rv  = (k == 11);
`else
            exp_gnt = 1'b0;
            exp_rv  = 1'b0;
`endif
            if (k > 1) tick();
            sample();
            chk($sformatf("starve_gnt_%0d", k),   32'(bus.dbg_gnt),    32'(exp_gnt));
            chk($sformatf("starve_stall_%0d", k), 32'(bus.cpu_stall),  32'(exp_gnt));
            chk($sformatf("starve_rv_%0d", k),    32'(bus.dbg_rvalid), 32'(exp_rv));
            if (exp_rv)
                chk("starve_dbg_data", 32'(bus.dbg_rdata), 32'(init_val(11'h040)));
            if (k == 10) begin
                chk("starve_cpu_addr",  32'(bus.mem_addr),  32'h030);
                chk("starve_cpu_rdata", 32'(bus.cpu_rdata), 32'(init_val(11'h030)));
            end
        end
        tick();
        bus.cpu_rd = 1'b0;
        sample();
        chk("cpu_gap_dbg_gnt", 32'(bus.dbg_gnt),   32'd1);
        chk("cpu_gap_stall",   32'(bus.cpu_stall), 32'd0);

        // CPU read+write together is a write.
        tick();
        bus.dbg_req   = 1'b0;
        bus.cpu_rd    = 1'b1;
        bus.cpu_wr    = 1'b1;
        bus.cpu_addr  = 11'h010;
        bus.cpu_wdata = 16'h1234;
        sample();
        chk("rdwr_mem_we", 32'(bus.mem_we), 32'd1);
        chk("rdwr_mem_re", 32'(bus.mem_re), 32'd0);
        tick();
        bus.cpu_wr = 1'b0;
        sample();
        chk("rdwr_next_re", 32'(bus.mem_re), 32'd1);
        tick();
        bus.cpu_rd = 1'b0;
        sample();
        chk("rdwr_readback", 32'(bus.cpu_rdata), 32'h1234);

        // Reset pulsed while a debug read is in flight.
        tick();
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 11'h00A;
        sample();
        chk("rstmid_gnt", 32'(bus.dbg_gnt), 32'd1);
        tick();
        bus.dbg_req = 1'b0;
        rst_n       = 1'b0;
        tick();
        rst_n = 1'b1;
        sample();
        chk("rstmid_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rstmid_rdata",  32'(bus.dbg_rdata),  32'd0);
        tick();
        sample();
        chk("rstmid_rvalid2", 32'(bus.dbg_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
